// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-reception controller.
// Holds the FSM state encoding, the header address codes and the wait-timer width.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_FIFO0   = 2'b00;
  localparam logic [1:0] ADDR_FIFO1   = 2'b01;
  localparam logic [1:0] ADDR_FIFO2   = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int TIMER_W = 7;

  function automatic logic is_valid_addr(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY state with a terminal-count compare.
// Clears whenever count_en drops, so every visit to the wait state starts from zero.
module router_wait_timer
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic count_en,
  output logic terminal
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + TIMER_W'(1);
    end else begin
      count <= '0;
    end
  end

  assign terminal = count_en && (count == TIMER_W'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/router_fsm.sv
// Packet-reception controller of the 1x3 router: Moore FSM driving the register,
// sync and FIFO strobes. Optional wait-state timeout under ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       timeout_drop
);

  // The timer compare must fit in TIMER_W bits and needs at least one wait cycle.
  if (WAIT_TIMEOUT < 2 || WAIT_TIMEOUT > (2 ** TIMER_W)) begin : g_bad_timeout
    $error("router_fsm: WAIT_TIMEOUT out of range");
  end

  state_t     state;
  state_t     next_state;
  logic [1:0] addr;
  logic [1:0] emp_sel;
  logic       emp;
  logic       srst;
  logic       timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DECODE_ADDRESS;
      addr  <= ADDR_FIFO0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid) begin
        addr <= data_in;
      end
    end
  end

  // While decoding, the header is still on data_in and addr has not loaded yet.
  assign emp_sel = (state == DECODE_ADDRESS) ? data_in : addr;

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    emp = 1'b0;
    case (emp_sel)
      ADDR_FIFO0: emp = fifo_empty_0;
      ADDR_FIFO1: emp = fifo_empty_1;
      ADDR_FIFO2: emp = fifo_empty_2;
      default:    emp = 1'b0;
    endcase
  end

  always_comb begin
    srst = 1'b0;
    case (addr)
      ADDR_FIFO0: srst = soft_reset_0;
      ADDR_FIFO1: srst = soft_reset_1;
      ADDR_FIFO2: srst = soft_reset_2;
      default:    srst = 1'b0;
    endcase
  end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic timer_tc;
  logic timeout_drop_q;

  router_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .count_en (state == WAIT_TILL_EMPTY),
    .terminal (timer_tc)
  );

  assign timeout_hit = timer_tc && !emp;

  // Registered so the pulse lines up with the first DECODE_ADDRESS cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_drop_q <= 1'b0;
    end else begin
      timeout_drop_q <= timeout_hit && !srst;
    end
  end

  assign timeout_drop = timeout_drop_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_drop = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid && is_valid_addr(data_in)) begin
          next_state = emp ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          next_state = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          next_state = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          next_state = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          next_state = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          next_state = LOAD_PARITY;
        end else begin
          next_state = LOAD_DATA;
        end
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (emp) begin
          next_state = LOAD_FIRST_DATA;
        end else if (timeout_hit) begin
          next_state = DECODE_ADDRESS;
        end
      end
      default: next_state = DECODE_ADDRESS;
    endcase

    // A read-timeout on the destination FIFO abandons the packet from any state.
    if (state != DECODE_ADDRESS && srst) begin
      next_state = DECODE_ADDRESS;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state)
      DECODE_ADDRESS:  detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      WAIT_TILL_EMPTY: busy = 1'b1;
      default:         detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: each stimulus cycle queues the expected output
// vector, and a negedge monitor pops and compares it against the DUT outputs.
module tb_router_fsm;

  // Expected vectors, bit order {detect_add,lfd,ld,laf,full,wen,rst_int,busy,timeout_drop}
  localparam logic [8:0] E_DA   = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_LFD  = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] E_LD   = 9'b0_0_1_0_0_1_0_0_0;
  localparam logic [8:0] E_FF   = 9'b0_0_0_0_1_0_0_1_0;
  localparam logic [8:0] E_LAF  = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] E_LP   = 9'b0_0_0_0_0_1_0_1_0;
  localparam logic [8:0] E_CPE  = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] E_WT   = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] E_DROP = 9'b1_0_0_0_0_0_0_0_1;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int TB_WAIT_TIMEOUT = 8;
`else
  localparam int TB_WAIT_TIMEOUT = 64;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, timeout_drop;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clock = ~clock;

  router_fsm #(
    .WAIT_TIMEOUT(TB_WAIT_TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy),
    .timeout_drop  (timeout_drop)
  );

  // Monitor: one expected vector is consumed per clock, sampled mid-cycle.
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      item_t      it;
      logic [8:0] act;
      it  = sb.pop_front();
      act = {detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy, timeout_drop};
      n_checks++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: outputs %b, expected %b (t=%0t)", it.name, act, it.exp, $time);
      end
    end
  end

  // Inputs are set just after a rising edge; the vector describes the state after the next one.
  task automatic step(input logic [8:0] exp, input string nm);
    item_t it;
    @(posedge clock);
    it.exp  = exp;
    it.name = nm;
    sb.push_back(it);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    pkt_valid     = 1'b0;
    data_in       = 2'b00;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;

    // Reset
    step(E_DA, "reset_0");
    step(E_DA, "reset_1");
    reset = 1'b0;
    step(E_DA, "idle");

    // Clean packet to FIFO 1: lfd, 4 x ld, parity load, parity check
    pkt_valid = 1'b1; data_in = 2'b01;
    step(E_LFD, "clean_lfd");
    data_in = 2'b00;
    step(E_LD, "clean_ld1");
    step(E_LD, "clean_ld2");
    step(E_LD, "clean_ld3");
    step(E_LD, "clean_ld4");
    pkt_valid = 1'b0;
    step(E_LP,  "clean_lp");
    step(E_CPE, "clean_cpe");
    step(E_DA,  "clean_done");
    step(E_DA,  "clean_idle");

    // Full on the 2nd payload cycle for 3 cycles, then full again at parity check
    pkt_valid = 1'b1; data_in = 2'b00;
    step(E_LFD, "full_lfd");
    step(E_LD,  "full_ld1");
    fifo_full = 1'b1;
    step(E_FF, "full_ff1");
    step(E_FF, "full_ff2");
    step(E_FF, "full_ff3");
    fifo_full = 1'b0;
    step(E_LAF, "full_laf");
    step(E_LD,  "full_ld_resume");
    pkt_valid = 1'b0;
    step(E_LP, "full_lp");
    fifo_full = 1'b1;
    step(E_CPE, "full_cpe");
    step(E_FF,  "cpe_to_ff");
    fifo_full = 1'b0; parity_done = 1'b1;
    step(E_LAF, "cpe_laf");
    step(E_DA,  "laf_parity_done");
    parity_done = 1'b0;
    step(E_DA, "full_idle");

    // fifo_full and !pkt_valid together: full wins; low_pkt_valid then routes to parity
    pkt_valid = 1'b1; data_in = 2'b00;
    step(E_LFD, "both_lfd");
    step(E_LD,  "both_ld");
    pkt_valid = 1'b0; fifo_full = 1'b1;
    step(E_FF, "both_full_wins");
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step(E_LAF, "both_laf");
    step(E_LP,  "laf_low_pkt");
    low_pkt_valid = 1'b0;
    step(E_CPE, "both_cpe");
    step(E_DA,  "both_done");

    // Busy destination FIFO 2
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b0;
    step(E_WT, "wait_1");
    data_in = 2'b00;
    step(E_WT, "wait_2");
    step(E_WT, "wait_3");
    step(E_WT, "wait_4");
    step(E_WT, "wait_5");
    fifo_empty_2 = 1'b1;
    step(E_LFD, "wait_lfd");
    step(E_LD,  "wait_ld");
    pkt_valid = 1'b0;
    step(E_LP,  "wait_lp");
    step(E_CPE, "wait_cpe");
    step(E_DA,  "wait_done");

    // Soft reset: another FIFO's soft reset is ignored, the addressed one aborts
    pkt_valid = 1'b1; data_in = 2'b00;
    step(E_LFD, "srst_lfd");
    step(E_LD,  "srst_ld");
    soft_reset_1 = 1'b1;
    step(E_LD, "srst_other_fifo");
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step(E_DA, "srst_abort");
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;
    step(E_DA, "srst_idle");

    // Soft reset out of WAIT_TILL_EMPTY
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b0;
    step(E_WT, "srst_wait_1");
    step(E_WT, "srst_wait_2");
    soft_reset_2 = 1'b1;
    step(E_DA, "srst_wait_abort");
    soft_reset_2 = 1'b0; pkt_valid = 1'b0; fifo_empty_2 = 1'b1;
    step(E_DA, "srst_wait_idle");

    // Invalid header 11 is ignored
    pkt_valid = 1'b1; data_in = 2'b11;
    step(E_DA, "addr11_a");
    step(E_DA, "addr11_b");
    pkt_valid = 1'b0;
    step(E_DA, "addr11_idle");

    // Mid-packet reset abandons the packet
    pkt_valid = 1'b1; data_in = 2'b01;
    step(E_LFD, "mrst_lfd");
    step(E_LD,  "mrst_ld");
    reset = 1'b1;
    step(E_DA, "mrst_reset");
    reset = 1'b0; pkt_valid = 1'b0;
    step(E_DA, "mrst_idle");

    // Wait timeout on FIFO 0 (indefinite wait when the feature is not built)
    pkt_valid = 1'b1; data_in = 2'b00; fifo_empty_0 = 1'b0;
    step(E_WT, "tmo_wait_0");
    pkt_valid = 1'b0;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    for (int i = 1; i < 8; i++) step(E_WT, $sformatf("tmo_wait_%0d", i));
    step(E_DROP, "tmo_drop");
    step(E_DA,   "tmo_after");
`else
    for (int i = 1; i < 20; i++) step(E_WT, $sformatf("tmo_wait_%0d", i));
    soft_reset_0 = 1'b1;
    step(E_DA, "tmo_srst_exit");
    soft_reset_0 = 1'b0;
    step(E_DA, "tmo_idle");
`endif
    fifo_empty_0 = 1'b1;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected vectors left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
